// File: rtl/alu_test_pkg.sv
// Shared definitions for the ALU vector sequencer: flag positions, vector field layout, FSM states.
package alu_test_pkg;

    // Bit positions of the flags inside the 4-bit flag field {CF, ZF, SF, OF}.
    localparam int unsigned CF     = 3;
    localparam int unsigned ZF     = 2;
    localparam int unsigned SF     = 1;
    localparam int unsigned OF     = 0;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } bist_state_e;

    // Vector layout, MSB first: {a, b, s, y_exp, C, Z, S, O}.
    function automatic int unsigned vec_width(input int unsigned width, input int unsigned sel_w);
        return 3 * width + sel_w + FLAG_W;
    endfunction

    function automatic int unsigned y_lsb();
        return FLAG_W;
    endfunction

    function automatic int unsigned s_lsb(input int unsigned width);
        return width + FLAG_W;
    endfunction

    function automatic int unsigned b_lsb(input int unsigned width, input int unsigned sel_w);
        return width + sel_w + FLAG_W;
    endfunction

    function automatic int unsigned a_lsb(input int unsigned width, input int unsigned sel_w);
        return 2 * width + sel_w + FLAG_W;
    endfunction

endpackage

// File: rtl/alu_bist_delay.sv
// Valid + payload shift register; an entry pushed at one edge appears at the output
// STAGES-1 cycles after it becomes visible in the first stage.
module alu_bist_delay #(
    parameter int unsigned STAGES = 1,
    parameter int unsigned PW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    output logic [PW-1:0] out_data
);

    logic [STAGES-1:0] vld_q;
    logic [PW-1:0]     dat_q [STAGES];

    // Shift valid and payload one stage per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            dat_q[0] <= in_data;
            for (int i = 1; i < int'(STAGES); i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = dat_q[STAGES-1];

endmodule

// File: rtl/alu_bist_sequencer.sv
// Self-checking vector sequencer: streams stored vectors into the ALU and counts mismatches.
module alu_bist_sequencer
    import alu_test_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned LATENCY = 0,
    parameter int unsigned ERR_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     num_vec,
    input  logic                       cmp_flags,
    input  logic                       vec_we,
    input  logic [$clog2(DEPTH)-1:0]   vec_addr,
    input  logic [3*WIDTH+SEL_W+3:0]   vec_wdata,
    output logic [WIDTH-1:0]           dut_a,
    output logic [WIDTH-1:0]           dut_b,
    output logic [SEL_W-1:0]           dut_s,
    input  logic [WIDTH-1:0]           dut_y,
    input  logic [3:0]                 dut_flags,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_count,
    output logic [$clog2(DEPTH)-1:0]   first_err_idx,
    output logic                       first_err_valid
);

    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned CW    = IW + 1;
    localparam int unsigned VW    = vec_width(WIDTH, SEL_W);
    localparam int unsigned PW    = IW + WIDTH + FLAG_W;
    localparam int unsigned DW    = $clog2(LATENCY + 1) + 1;
    localparam int unsigned Y_LSB = y_lsb();
    localparam int unsigned S_LSB = s_lsb(WIDTH);
    localparam int unsigned B_LSB = b_lsb(WIDTH, SEL_W);
    localparam int unsigned A_LSB = a_lsb(WIDTH, SEL_W);

    logic [VW-1:0] mem [DEPTH];

    bist_state_e      state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    num_q, num_d;
    logic             cmp_q, cmp_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [IW-1:0]    fidx_q, fidx_d;
    logic             fval_q, fval_d;

    logic             push;
    logic [PW-1:0]    push_data;
    logic             chk_valid;
    logic [PW-1:0]    chk_data;
    logic [VW-1:0]    rd_vec;
    logic [CW-1:0]    num_clamped;
    logic             last_vec;
    logic             mismatch;
    logic [WIDTH-1:0] exp_y;
    logic [3:0]       exp_f;
    logic [IW-1:0]    exp_idx;

    assign rd_vec      = mem[idx_q];
    assign num_clamped = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
    assign last_vec    = ({1'b0, idx_q} == (num_q - 1'b1));
    assign push_data   = {idx_q, rd_vec[Y_LSB +: WIDTH], rd_vec[FLAG_W-1:0]};

    assign exp_f   = chk_data[FLAG_W-1:0];
    assign exp_y   = chk_data[FLAG_W +: WIDTH];
    assign exp_idx = chk_data[FLAG_W+WIDTH +: IW];

    // Case equality so that X/Z on the ALU outputs is reported as a mismatch in simulation.
    assign mismatch = chk_valid &&
                      ((dut_y !== exp_y) || (cmp_q && (dut_flags !== exp_f)));

    assign busy            = (state_q == StIssue) || (state_q == StDrain);
    assign done            = (state_q == StDone);
    assign pass            = done && (err_q == '0);
    assign err_count       = err_q;
    assign first_err_idx   = fidx_q;
    assign first_err_valid = fval_q;
    assign dut_a           = a_q;
    assign dut_b           = b_q;
    assign dut_s           = s_q;

    // Vector storage; writes are dropped while a run is in progress.
    always_ff @(posedge clk) begin
        if (vec_we && !busy) begin
            mem[vec_addr] <= vec_wdata;
        end
    end

    alu_bist_delay #(
        .STAGES (LATENCY + 1),
        .PW     (PW)
    ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push),
        .in_data   (push_data),
        .out_valid (chk_valid),
        .out_data  (chk_data)
    );

    // State and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            num_q   <= '0;
            cmp_q   <= 1'b0;
            drain_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            cmp_q   <= cmp_d;
            drain_q <= drain_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fval_q  <= fval_d;
        end
    end

    // Next-state: run sequencing plus mismatch bookkeeping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        cmp_d   = cmp_q;
        drain_d = drain_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fval_d  = fval_q;
        push    = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    num_d   = num_clamped;
                    cmp_d   = cmp_flags;
                    idx_d   = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fval_d  = 1'b0;
                    state_d = (num_vec == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                push = 1'b1;
                a_d  = rd_vec[A_LSB +: WIDTH];
                b_d  = rd_vec[B_LSB +: WIDTH];
                s_d  = rd_vec[S_LSB +: SEL_W];
                if (last_vec) begin
                    state_d = StDrain;
                    drain_d = DW'(LATENCY);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDrain: begin
                // Stay LATENCY+1 cycles so the last pushed entry is compared.
                if (drain_q == '0) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // The delay line is always empty when a start is accepted, so no overlap with clearing.
        if (mismatch) begin
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end
            if (!fval_q) begin
                fval_d = 1'b1;
                fidx_d = exp_idx;
            end
        end
    end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Bench for alu_bist_sequencer: a combinational-latency instance (ERR_W=2) checked every cycle
// against a run-level model, and a LATENCY=2 instance driven by a two-stage registered ALU.
module tb_alu_bist_sequencer;

    localparam int unsigned L0   = 0;
    localparam int unsigned SAT0 = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start0 = 1'b0, start1 = 1'b0;
    logic [3:0]   num_vec = '0;
    logic         cmp_flags = 1'b0;
    logic         vec_we = 1'b0;
    logic [2:0]   vec_addr = '0;
    logic [103:0] vec_wdata = '0;
    logic         alu_mode = 1'b0;

    logic [31:0]  d0_a, d0_b, d0_y, d1_a, d1_b, d1_y;
    logic [3:0]   d0_s, d0_f, d1_s, d1_f;
    logic         busy0, done0, pass0, fval0, busy1, done1, pass1, fval1;
    logic [1:0]   err0;
    logic [7:0]   err1;
    logic [2:0]   fidx0, fidx1;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench copy of what the sequencer memory should hold.
    logic [31:0] tm_a [8];
    logic [31:0] tm_b [8];
    logic [3:0]  tm_s [8];
    logic [31:0] tm_y [8];
    logic [3:0]  tm_f [8];

    // Expected outcome of the current run on instance 0.
    int   exp_n, exp_err, exp_fi;
    bit   exp_fv;
    bit   running = 0;
    int   cyc = 0;
    int   bc;

    always #5 clk = ~clk;

    // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor. Returns {y, C, Z, S, O}.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
        logic [32:0] w;
        logic [31:0] y;
        logic        c, o;
        c = 1'b0;
        o = 1'b0;
        w = '0;
        case (s)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                y = w[31:0];
                c = w[32];
                o = (a[31] == b[31]) && (y[31] != a[31]);
            end
            4'd1: begin
                w = {1'b0, a} - {1'b0, b};
                y = w[31:0];
                c = w[32];
                o = (a[31] != b[31]) && (y[31] != a[31]);
            end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            default: y = '0;
        endcase
        return {y, c, (y == 32'd0), y[31], o};
    endfunction

    // ALU environment: combinational, or two registered stages.
    logic [35:0] comb0, comb1, p0_1, p0_2, p1_1, p1_2;
    assign comb0 = alu_ref(d0_a, d0_b, d0_s);
    assign comb1 = alu_ref(d1_a, d1_b, d1_s);
    always @(posedge clk) begin
        p0_1 <= comb0;
        p0_2 <= p0_1;
        p1_1 <= comb1;
        p1_2 <= p1_1;
    end
    assign d0_y = alu_mode ? p0_2[35:4] : comb0[35:4];
    assign d0_f = alu_mode ? p0_2[3:0] : comb0[3:0];
    assign d1_y = p1_2[35:4];
    assign d1_f = p1_2[3:0];

    alu_bist_sequencer #(
        .WIDTH(32), .SEL_W(4), .DEPTH(8), .LATENCY(L0), .ERR_W(2)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start0), .num_vec(num_vec), .cmp_flags(cmp_flags),
        .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
        .dut_a(d0_a), .dut_b(d0_b), .dut_s(d0_s), .dut_y(d0_y), .dut_flags(d0_f),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_idx(fidx0), .first_err_valid(fval0)
    );

    alu_bist_sequencer #(
        .WIDTH(32), .SEL_W(4), .DEPTH(8), .LATENCY(2), .ERR_W(8)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .num_vec(num_vec), .cmp_flags(cmp_flags),
        .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
        .dut_a(d1_a), .dut_b(d1_b), .dut_s(d1_s), .dut_y(d1_y), .dut_flags(d1_f),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_idx(fidx1), .first_err_valid(fval1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle check of instance 0 against the run-level model.
    int cmp_k;
    bit cmp_busy;
    always @(negedge clk) begin
        if (running) begin
            cyc++;
            cmp_busy = (exp_n > 0) && (cyc <= exp_n + int'(L0) + 1);
            chk("busy", busy0, cmp_busy);
            chk("done", done0, !cmp_busy);
            if (exp_n > 0 && cyc >= 2) begin
                cmp_k = (cyc - 2 > exp_n - 1) ? exp_n - 1 : cyc - 2;
                chk("dut_a", d0_a, tm_a[cmp_k]);
                chk("dut_b", d0_b, tm_b[cmp_k]);
                chk("dut_s", d0_s, tm_s[cmp_k]);
            end
            if (!cmp_busy) begin
                chk("pass", pass0, exp_err == 0);
                chk("err_count", err0, exp_err);
                chk("first_err_valid", fval0, exp_fv);
                chk("first_err_idx", fidx0, exp_fi);
            end else begin
                chk("pass_low_busy", pass0, 0);
            end
        end
    end

    task automatic write_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] s, input logic [31:0] y, input logic [3:0] f);
        @(posedge clk);
        #1;
        vec_we    = 1'b1;
        vec_addr  = 3'(i);
        vec_wdata = {a, b, s, y, f};
        tm_a[i] = a; tm_b[i] = b; tm_s[i] = s; tm_y[i] = y; tm_f[i] = f;
        @(posedge clk);
        #1;
        vec_we = 1'b0;
    endtask

    // Base operand table; mode 0 correct, 1 vec4 y+1, 2 ZF flipped on 2 and 5, 3 all y^1.
    logic [31:0] base_a [8] = '{32'h64, 32'h10, 32'hF0F0, 32'h1234, 32'h64, 32'hFF,
                                32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [31:0] base_b [8] = '{32'h33, 32'h20, 32'h0F0F, 32'h4321, 32'h33, 32'hFF,
                                32'h1, 32'h1};
    logic [3:0]  base_s [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd4, 4'd0, 4'd0};

    task automatic load(input int mode);
        logic [35:0] r;
        logic [31:0] y;
        logic [3:0]  f;
        for (int i = 0; i < 8; i++) begin
            r = alu_ref(base_a[i], base_b[i], base_s[i]);
            y = r[35:4];
            f = r[3:0];
            if (mode == 1 && i == 4) y = y + 1;
            if (mode == 2 && (i == 2 || i == 5)) f[2] = ~f[2];
            if (mode == 3) y[0] = ~y[0];
            write_vec(i, base_a[i], base_b[i], base_s[i], y, f);
        end
    endtask

    task automatic model(input int n, input bit cf);
        logic [35:0] r;
        bit mis;
        exp_n = (n > 8) ? 8 : n;
        exp_err = 0;
        exp_fv = 0;
        exp_fi = 0;
        for (int i = 0; i < exp_n; i++) begin
            r = alu_ref(tm_a[i], tm_b[i], tm_s[i]);
            mis = (r[35:4] != tm_y[i]) || (cf && (r[3:0] != tm_f[i]));
            if (mis) begin
                if (exp_err < SAT0) exp_err++;
                if (!exp_fv) begin
                    exp_fv = 1;
                    exp_fi = i;
                end
            end
        end
    endtask

    // Start a run on instance 0; optionally write vector 0 in the same cycle.
    task automatic launch0(input int n, input bit cf, input bit wr0, input bit use_model);
        logic [35:0] r;
        @(posedge clk);
        #1;
        start0    = 1'b1;
        num_vec   = 4'(n);
        cmp_flags = cf;
        if (wr0) begin
            r = alu_ref(base_a[0], base_b[0], base_s[0]);
            vec_we    = 1'b1;
            vec_addr  = 3'd0;
            vec_wdata = {base_a[0], base_b[0], base_s[0], r[35:4], r[3:0]};
            tm_a[0] = base_a[0]; tm_b[0] = base_b[0]; tm_s[0] = base_s[0];
            tm_y[0] = r[35:4]; tm_f[0] = r[3:0];
        end
        model(n, cf);
        @(posedge clk);
        #1;
        start0 = 1'b0;
        vec_we = 1'b0;
        cyc = 0;
        running = use_model;
    endtask

    task automatic wait_done(input bit which, input string name, output int busy_cnt);
        logic dn;
        busy_cnt = 0;
        dn = 1'b0;
        #2;
        for (int i = 0; i < 200; i++) begin
            dn = which ? done1 : done0;
            if (dn) break;
            if (which ? busy1 : busy0) busy_cnt++;
            @(posedge clk);
            #3;
        end
        chk({name, "_reached_done"}, dn, 1);
        @(negedge clk);
        #1;
        running = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_fval", fval0, 0);
        chk("rst_dut_a", d0_a, 0);
        chk("rst_dut_s", d0_s, 0);
        reset = 1'b0;

        // Pin the reference ALU with hand-computed values.
        chk("ref_add", alu_ref(32'h64, 32'h33, 4'd0), {32'h97, 4'b0000});
        chk("ref_sub", alu_ref(32'h10, 32'h20, 4'd1), {32'hFFFFFFF0, 4'b1010});
        chk("ref_ovf", alu_ref(32'h7FFFFFFF, 32'h1, 4'd0), {32'h80000000, 4'b0011});

        // Single vector, written in the same cycle as start.
        launch0(1, 1, 1, 1);
        wait_done(0, "t1", bc);
        chk("t1_busy_cycles", bc, 2);
        chk("t1_pass", pass0, 1);
        chk("t1_err", err0, 0);

        // Seven vectors, vector 4 expected y corrupted.
        load(1);
        launch0(7, 1, 0, 1);
        chk("t2_model_err", exp_err, 1);
        chk("t2_model_fi", exp_fi, 4);
        wait_done(0, "t2", bc);
        chk("t2_err", err0, 1);
        chk("t2_fidx", fidx0, 4);
        chk("t2_fval", fval0, 1);
        chk("t2_pass", pass0, 0);

        // Wrong ZF on 2 and 5: counted with flags, ignored without; num_vec=15 clamps to 8.
        load(2);
        launch0(8, 1, 0, 1);
        wait_done(0, "t3a", bc);
        chk("t3a_err", err0, 2);
        chk("t3a_fidx", fidx0, 2);
        launch0(15, 0, 0, 1);
        wait_done(0, "t3b", bc);
        chk("t3b_busy_cycles", bc, 9);
        chk("t3b_err", err0, 0);
        chk("t3b_pass", pass0, 1);

        // Registered ALU: LATENCY=2 instance passes, LATENCY=0 instance does not.
        load(0);
        @(posedge clk);
        #1;
        start1 = 1'b1;
        num_vec = 4'd8;
        cmp_flags = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done(1, "t4a", bc);
        chk("t4a_busy_cycles", bc, 11);
        chk("t4a_pass", pass1, 1);
        chk("t4a_err", err1, 0);
        chk("t4a_fval", fval1, 0);
        alu_mode = 1'b1;
        launch0(8, 1, 0, 0);
        wait_done(0, "t4b", bc);
        chk("t4b_err_nonzero", err0 != 0, 1);
        chk("t4b_pass", pass0, 0);
        alu_mode = 1'b0;

        // Saturation, then an empty run.
        load(3);
        launch0(8, 1, 0, 1);
        wait_done(0, "t5a", bc);
        chk("t5a_err_sat", err0, 3);
        chk("t5a_fidx", fidx0, 0);
        launch0(0, 1, 0, 1);
        wait_done(0, "t5b", bc);
        chk("t5b_busy_cycles", bc, 0);
        chk("t5b_pass", pass0, 1);
        chk("t5b_err", err0, 0);

        // Reset while vector 3 is being issued.
        launch0(8, 1, 0, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("t6_pre_busy", busy0, 1);
        chk("t6_pre_err", err0, 2);
        reset = 1'b1;
        #1;
        chk("t6_busy", busy0, 0);
        chk("t6_done", done0, 0);
        chk("t6_err", err0, 0);
        chk("t6_fval", fval0, 0);
        chk("t6_dut_a", d0_a, 0);
        chk("t6_dut_b", d0_b, 0);
        @(negedge clk);
        reset = 1'b0;

        // Write attempted while busy must not land; readback run must still pass.
        load(0);
        launch0(8, 1, 0, 1);
        @(posedge clk);
        #1;
        vec_we = 1'b1;
        vec_addr = 3'd1;
        vec_wdata = '1;
        @(posedge clk);
        #1;
        vec_we = 1'b0;
        wait_done(0, "t7a", bc);
        chk("t7a_pass", pass0, 1);
        launch0(8, 1, 0, 1);
        wait_done(0, "t7b", bc);
        chk("t7b_pass", pass0, 1);
        chk("t7b_err", err0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
